// File: rtl/test_mem_pkg.sv
// Shared constants and types for the latency test memory.
// Imported by the port controller and the memory top.
package test_mem_pkg;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE,
    STALL
  } port_state_e;

endpackage

// File: rtl/test_mem_port_ctrl.sv
// Per-port latency controller: counts wait cycles, flags completion,
// and aborts the request silently when val drops mid-stall.
module test_mem_port_ctrl
  import test_mem_pkg::*;
#(
  parameter int LAT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic val,
  output logic stall,
  output logic done
);

  localparam logic [CNT_W-1:0] L = CNT_W'(LAT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  port_state_e      state;

  always_comb begin
    state = (cnt_q == '0) ? IDLE : STALL;
    // cnt never exceeds L, so != doubles as < here
    stall = rst && val && (cnt_q != L);
    done  = rst && val && (cnt_q == L);
    cnt_d = '0;
    unique case (state)
      IDLE:    if (stall) cnt_d = CNT_W'(1);
      STALL:   if (stall) cnt_d = cnt_q + CNT_W'(1);
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/test_latency_memory.sv
// Two-port behavioural test memory with programmable fixed latency
// per port; contents loaded from the bench via init()/clear().
module test_latency_memory
  import test_mem_pkg::*;
#(
  parameter int p_addr_nbits   = 16,
  parameter int p_data_nbits   = 32,
  parameter int p_num_words    = 256,
  parameter int p_imem_latency = 0,
  parameter int p_dmem_latency = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      imem_val,
  input  logic [p_addr_nbits-1:0]   imem_addr,
  output logic                      imem_wait,
  output logic [p_data_nbits-1:0]   imem_rdata,
  output logic                      imem_err,
  input  logic                      dmem_val,
  input  logic                      dmem_type,
  input  logic [p_addr_nbits-1:0]   dmem_addr,
  input  logic [p_data_nbits/8-1:0] dmem_wstrb,
  input  logic [p_data_nbits-1:0]   dmem_wdata,
  output logic                      dmem_wait,
  output logic [p_data_nbits-1:0]   dmem_rdata,
  output logic                      dmem_err
);

  localparam int          IDX_W = $clog2(p_num_words);
  localparam int          NB    = p_data_nbits / 8;
  localparam logic [31:0] LIMIT = 32'(4 * p_num_words);

  logic [p_data_nbits-1:0] mem_q [p_num_words];

  logic i_done;
  logic d_done;
  logic d_we;
  logic [IDX_W-1:0] i_idx;
  logic [IDX_W-1:0] d_idx;

  function automatic logic bad_addr(
    input logic [p_addr_nbits-1:0] a
  );
    return (a[1:0] != 2'b00) || (32'(a) >= LIMIT);
  endfunction

  test_mem_port_ctrl #(.LAT(p_imem_latency)) u_ictrl (
    .clk   (clk),
    .rst   (rst),
    .val   (imem_val),
    .stall (imem_wait),
    .done  (i_done)
  );

  test_mem_port_ctrl #(.LAT(p_dmem_latency)) u_dctrl (
    .clk   (clk),
    .rst   (rst),
    .val   (dmem_val),
    .stall (dmem_wait),
    .done  (d_done)
  );

  assign i_idx = imem_addr[IDX_W+1:2];
  assign d_idx = dmem_addr[IDX_W+1:2];

  assign imem_err = i_done && bad_addr(imem_addr);
  assign dmem_err = d_done && bad_addr(dmem_addr);

  assign imem_rdata = (i_done && !imem_err) ? mem_q[i_idx] : 'x;
  assign dmem_rdata = (d_done && !dmem_err) ? mem_q[d_idx] : 'x;

  assign d_we = d_done && !dmem_err && (dmem_type == MEM_WRITE);

  // No reset: contents survive rst, and the bench tasks also write here
  always @(posedge clk) begin
    if (d_we) begin
      for (int b = 0; b < NB; b++) begin
        if (dmem_wstrb[b]) begin
          mem_q[d_idx][8*b +: 8] <= dmem_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic init(
    input logic [p_addr_nbits-1:0] addr,
    input logic [p_data_nbits-1:0] data
  );
    mem_q[addr[IDX_W+1:2]] = data;
  endtask

  task automatic clear();
    for (int i = 0; i < p_num_words; i++) begin
      mem_q[i] = '0;
    end
  endtask

endmodule

// File: tb/tb_test_latency_memory.sv
// Directed bench: three memories (latency 0/0, 5/3, 0/4) share one
// stimulus bus; each test reads the outputs of the instance under test.
module tb_test_latency_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_val;
  logic [15:0] imem_addr;
  logic        dmem_val;
  logic        dmem_type;
  logic [15:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;

  logic        iwait  [3];
  logic        ierr   [3];
  logic [31:0] irdata [3];
  logic        dwait  [3];
  logic        derr   [3];
  logic [31:0] drdata [3];

  int   errs   = 0;
  int   checks = 0;
  logic seen_w0 = 1'b0;

  always #5 clk = ~clk;

  test_latency_memory #(.p_imem_latency(0), .p_dmem_latency(0)) u0 (
    .clk(clk), .rst(rst),
    .imem_val(imem_val), .imem_addr(imem_addr),
    .imem_wait(iwait[0]), .imem_rdata(irdata[0]), .imem_err(ierr[0]),
    .dmem_val(dmem_val), .dmem_type(dmem_type), .dmem_addr(dmem_addr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_wait(dwait[0]), .dmem_rdata(drdata[0]), .dmem_err(derr[0])
  );

  test_latency_memory #(.p_imem_latency(5), .p_dmem_latency(3)) u1 (
    .clk(clk), .rst(rst),
    .imem_val(imem_val), .imem_addr(imem_addr),
    .imem_wait(iwait[1]), .imem_rdata(irdata[1]), .imem_err(ierr[1]),
    .dmem_val(dmem_val), .dmem_type(dmem_type), .dmem_addr(dmem_addr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_wait(dwait[1]), .dmem_rdata(drdata[1]), .dmem_err(derr[1])
  );

  test_latency_memory #(.p_imem_latency(0), .p_dmem_latency(4)) u2 (
    .clk(clk), .rst(rst),
    .imem_val(imem_val), .imem_addr(imem_addr),
    .imem_wait(iwait[2]), .imem_rdata(irdata[2]), .imem_err(ierr[2]),
    .dmem_val(dmem_val), .dmem_type(dmem_type), .dmem_addr(dmem_addr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_wait(dwait[2]), .dmem_rdata(drdata[2]), .dmem_err(derr[2])
  );

  always @(negedge clk) begin
    if (rst && (iwait[0] || dwait[0])) seen_w0 <= 1'b1;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic imem_op(
    input  int          k,
    input  logic [15:0] a,
    output int          w,
    output logic [31:0] d,
    output logic        e
  );
    imem_val  = 1'b1;
    imem_addr = a;
    w = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!iwait[k]) break;
      w++;
      @(posedge clk); #1;
    end
    d = irdata[k];
    e = ierr[k];
    @(posedge clk); #1;
    imem_val = 1'b0;
    idle();
  endtask

  task automatic dmem_op(
    input  int          k,
    input  logic        t,
    input  logic [15:0] a,
    input  logic [3:0]  s,
    input  logic [31:0] wd,
    output int          w,
    output logic [31:0] d,
    output logic        e
  );
    dmem_val   = 1'b1;
    dmem_type  = t;
    dmem_addr  = a;
    dmem_wstrb = s;
    dmem_wdata = wd;
    w = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!dwait[k]) break;
      w++;
      @(posedge clk); #1;
    end
    d = drdata[k];
    e = derr[k];
    @(posedge clk); #1;
    dmem_val  = 1'b0;
    dmem_type = 1'b0;
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          w;
    logic [31:0] d;
    logic        e;

    rst        = 1'b0;
    imem_val   = 1'b1;
    imem_addr  = 16'h0000;
    dmem_val   = 1'b0;
    dmem_type  = 1'b0;
    dmem_addr  = '0;
    dmem_wstrb = '0;
    dmem_wdata = '0;
    #2;
    chk("rst_iwait_u1", 32'(iwait[1]), 32'd0);
    chk("rst_ierr_u0", 32'(ierr[0]), 32'd0);
    chk("rst_irdata_u0", irdata[0], 'x);
    imem_val = 1'b0;

    u0.clear(); u1.clear(); u2.clear();
    u0.init(16'h0000, 32'h3); u0.init(16'h0004, 32'h1);
    u1.init(16'h0000, 32'h3); u1.init(16'h0004, 32'h1);
    u2.init(16'h0000, 32'h3); u2.init(16'h0004, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    idle();

    imem_op(0, 16'h0000, w, d, e);
    chk("l0_rd0_waits", 32'(w), 32'd0);
    chk("l0_rd0_data", d, 32'h3);
    imem_op(0, 16'h0004, w, d, e);
    chk("l0_rd4_data", d, 32'h1);
    chk("l0_rd4_err", 32'(e), 32'd0);
    @(negedge clk);
    chk("l0_noval_rdata", irdata[0], 'x);
    idle();

    dmem_op(1, 1'b1, 16'h0008, 4'hf, 32'hdeadbeef, w, d, e);
    chk("l3_wr_waits", 32'(w), 32'd3);
    chk("l3_wr_err", 32'(e), 32'd0);
    chk("l3_wr_olddata", d, 32'h0);
    dmem_op(1, 1'b0, 16'h0008, 4'h0, 32'h0, w, d, e);
    chk("l3_rd_waits", 32'(w), 32'd3);
    chk("l3_rd_data", d, 32'hdeadbeef);

    dmem_op(1, 1'b1, 16'h0008, 4'h1, 32'h00000011, w, d, e);
    dmem_op(1, 1'b0, 16'h0008, 4'h0, 32'h0, w, d, e);
    chk("strb_rd_data", d, 32'hdeadbe11);

    dmem_val   = 1'b1;
    dmem_type  = 1'b1;
    dmem_addr  = 16'h000c;
    dmem_wstrb = 4'hf;
    dmem_wdata = 32'h12345678;
    @(negedge clk);
    chk("abort_wait1", 32'(dwait[2]), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_wait2", 32'(dwait[2]), 32'd1);
    @(posedge clk); #1;
    dmem_val  = 1'b0;
    dmem_type = 1'b0;
    idle();
    dmem_op(2, 1'b0, 16'h000c, 4'h0, 32'h0, w, d, e);
    chk("abort_rd_waits", 32'(w), 32'd4);
    chk("abort_rd_data", d, 32'h0);

    dmem_op(0, 1'b0, 16'h0002, 4'h0, 32'h0, w, d, e);
    chk("mis_err", 32'(e), 32'd1);
    chk("mis_rdata", d, 'x);
    imem_op(0, 16'h0002, w, d, e);
    chk("imis_err", 32'(e), 32'd1);
    dmem_op(0, 1'b1, 16'h0400, 4'hf, 32'hffffffff, w, d, e);
    chk("oor_err", 32'(e), 32'd1);
    dmem_op(0, 1'b0, 16'h0000, 4'h0, 32'h0, w, d, e);
    chk("oor_nowrite", d, 32'h3);

    imem_val   = 1'b1;
    imem_addr  = 16'h0004;
    dmem_val   = 1'b1;
    dmem_type  = 1'b1;
    dmem_addr  = 16'h0004;
    dmem_wstrb = 4'hf;
    dmem_wdata = 32'h000000aa;
    @(negedge clk);
    chk("same_pre_write", irdata[0], 32'h1);
    @(posedge clk); #1;
    imem_val  = 1'b0;
    dmem_val  = 1'b0;
    dmem_type = 1'b0;
    idle();
    imem_op(0, 16'h0004, w, d, e);
    chk("same_post_write", d, 32'haa);

    imem_val  = 1'b1;
    imem_addr = 16'h0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_wait_pre", 32'(iwait[1]), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_wait_low", 32'(iwait[1]), 32'd0);
    chk("rst_mid_rdata", irdata[1], 'x);
    @(posedge clk); #1;
    rst = 1'b1;
    imem_op(1, 16'h0000, w, d, e);
    chk("rst_after_waits", 32'(w), 32'd5);
    chk("rst_after_data", d, 32'h3);

    chk("u0_never_wait", 32'(seen_w0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
